// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter_pkg
//  Purpose  : Shared constants and helpers for the multi-master SRAM
//             subsystem (default bus widths, master-count limit, master-id
//             width helper).
//  Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    // Default bus widths of the memory subsystem.
    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 32;

    // Largest number of masters the arbiter is built for.
    localparam int c_MAX_NUM_M  = 8;

    // Width of a master id; a single master still gets a 1-bit id so that
    // every id-carrying signal has a legal width.
    function automatic int id_width(input int num_m);
        return (num_m > 1) ? $clog2(num_m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Searches the request vector starting at
//             the master after the last one granted and grants at most one
//             requester per cycle.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             i_req           - one request bit per master
//             i_advance       - a grant is being taken this cycle
//             o_grant         - one-hot grant (combinational)
//             o_grant_idx     - index of the granted master
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_M = 2,
    localparam int ID_W = id_width(NUM_M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] i_req,
    input  logic             i_advance,
    output logic [NUM_M-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx
);

    logic [ID_W-1:0]  r_last;
    logic [ID_W-1:0]  w_cand;
    logic [ID_W-1:0]  w_idx;
    logic [NUM_M-1:0] w_grant;
    logic             w_found;

    // First requester found walking upward from last_grant+1, wrapping.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            w_cand = ID_W'((int'(r_last) + i) % NUM_M);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                w_grant[w_cand]  = 1'b1;
                w_idx            = w_cand;
            end
        end
    end

    // Reset points at the highest master so master 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ID_W'(NUM_M - 1);
        end else if (i_advance && w_found) begin
            r_last <= w_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Single-port data RAM shared by NUM_M masters through a
//             round-robin arbiter, with byte-enable writes and a RD_LAT-deep
//             read pipeline tagged with the requesting master id.
//  Ports    : clk, rst    - clock, asynchronous active-high reset
//             m_ce_i      - request valid per master
//             m_we_i      - 1 = write, 0 = read, per master
//             m_addr_i    - byte address, ADDR_W per master
//             m_sel_i     - byte enables, SEL_W per master
//             m_data_i    - write data, DATA_W per master
//             m_stall_o   - request not accepted this cycle
//             m_rvalid_o  - one-cycle read-data-valid pulse
//             m_data_o    - read data, held until the next rvalid
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_ce_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_M*(DATA_W/8)-1:0] m_sel_i,
    input  logic [NUM_M*DATA_W-1:0] m_data_i,
    output logic [NUM_M-1:0]        m_stall_o,
    output logic [NUM_M-1:0]        m_rvalid_o,
    output logic [NUM_M*DATA_W-1:0] m_data_o
);

    localparam int c_SEL_W    = DATA_W / 8;
    localparam int c_BYTE_OFF = $clog2(c_SEL_W);
    localparam int c_ID_W     = id_width(NUM_M);
    localparam int c_DEPTH    = 1 << DEPTH_LOG2;

    // One read-pipeline stage: which master asked and the word it gets.
    typedef struct packed {
        logic              valid;
        logic [c_ID_W-1:0] id;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    logic [NUM_M-1:0]      w_req;
    logic [NUM_M-1:0]      w_grant;
    logic [c_ID_W-1:0]     w_gidx;
    logic                  w_any;
    logic                  w_we;
    logic                  w_wr_en;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [c_SEL_W-1:0]    w_sel;
    logic [DATA_W-1:0]     w_wdata;
    rd_stage_t             w_new;
    rd_stage_t             w_exit;

    logic [DATA_W-1:0]        r_mem [c_DEPTH];
    logic [NUM_M-1:0]         r_rvalid;
    logic [NUM_M*DATA_W-1:0]  r_rdata;

    // No grants while reset is held, so every requester sees a stall.
    assign w_req = m_ce_i & ~{NUM_M{rst}};

    rr_arbiter #(
        .NUM_M       (NUM_M)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_advance   (w_any),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    assign w_any     = |w_grant;
    assign m_stall_o = m_ce_i & ~w_grant;

    // Granted master's request; upper address bits drop out, so addresses
    // alias modulo the RAM size.
    assign w_we    = m_we_i[w_gidx];
    assign w_widx  = m_addr_i[int'(w_gidx)*ADDR_W + c_BYTE_OFF +: DEPTH_LOG2];
    assign w_sel   = m_sel_i[int'(w_gidx)*c_SEL_W +: c_SEL_W];
    assign w_wdata = m_data_i[int'(w_gidx)*DATA_W +: DATA_W];
    assign w_wr_en = w_any & w_we;

    // Byte-enable write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < c_SEL_W; k++) begin
                if (w_sel[k]) begin
                    r_mem[w_widx][k*8 +: 8] <= w_wdata[k*8 +: 8];
                end
            end
        end
    end

    // Read sampled at the grant edge. Only one access is granted per cycle,
    // so a read right after a write sees the written word.
    always_comb begin
        w_new       = '0;
        w_new.valid = w_any & ~w_we;
        w_new.id    = w_gidx;
        w_new.data  = r_mem[w_widx];
    end

    // The output registers form the last stage, so RD_LAT-1 stages sit
    // between the grant edge and the edge that loads m_data_o/m_rvalid_o.
    generate
        if (RD_LAT == 1) begin : g_no_pipe
            assign w_exit = w_new;
        end else begin : g_pipe
            rd_stage_t r_pipe [RD_LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_new;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_exit = r_pipe[RD_LAT-2];
        end
    endgenerate

    // Pipeline exit: pulse the tagged master's rvalid and load its data,
    // other masters keep their last returned word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_exit.valid) begin
                r_rvalid[w_exit.id]                        <= 1'b1;
                r_rdata[int'(w_exit.id)*DATA_W +: DATA_W]  <= w_exit.data;
            end
        end
    end

    assign m_rvalid_o = r_rvalid;
    assign m_data_o   = r_rdata;

endmodule
`default_nettype wire
